// File: rtl/vram_rdarb_pkg.sv
// Shared types and defaults for the two-port VRAM read arbiter.
package vram_rdarb_pkg;

  typedef logic port_id_t;

  typedef enum logic {
    StIdle,
    StAddr
  } ar_state_e;

  localparam logic [8:0]  DefBurstLen    = 9'd64;
  localparam int unsigned DefOutstanding = 4;

endpackage

// File: rtl/vram_rdarb_ordfifo.sv
// Order FIFO: remembers which port owns each accepted burst so R beats can be routed back.
module vram_rdarb_ordfifo
  import vram_rdarb_pkg::*;
#(
  parameter int unsigned Depth = DefOutstanding
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  port_id_t din,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output port_id_t head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_rdarb.sv
// Two-port AXI read arbiter for VRAM fetch; R beats return to ports in AR issue order.
// Define VRAM_RDARB_RR_EN for round-robin arbitration (default: port 0 fixed priority).
module vram_rdarb
  import vram_rdarb_pkg::*;
#(
  parameter logic [8:0]  BURSTLEN           = DefBurstLen,
  parameter int unsigned OUTSTANDING        = DefOutstanding,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,

  input  logic [31:0]                   S0_ARADDR,
  input  logic                          S0_ARVALID,
  output logic                          S0_ARREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] S0_RDATA,
  output logic                          S0_RVALID,
  output logic                          S0_RLAST,
  input  logic                          S0_RREADY,

  input  logic [31:0]                   S1_ARADDR,
  input  logic                          S1_ARVALID,
  output logic                          S1_ARREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] S1_RDATA,
  output logic                          S1_RVALID,
  output logic                          S1_RLAST,
  input  logic                          S1_RREADY,

  output logic [31:0]                   M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,

  output logic                          BUSY
);

  localparam logic [8:0] ArLenFull = BURSTLEN - 9'd1;

  ar_state_e state_q;
  port_id_t  gnt_q;
  logic      arvalid_q;
  port_id_t  pick;
  logic      any_req, grant, ar_hs;
  logic      ord_full, ord_empty;
  port_id_t  ord_head;
  logic      r_sel0, r_sel1, r_pop;

  assign any_req = S0_ARVALID | S1_ARVALID;
  assign grant   = (state_q == StIdle) & ~ord_full & any_req;
  assign ar_hs   = arvalid_q & M_AXI_ARREADY;

`ifdef VRAM_RDARB_RR_EN
  port_id_t last_q;

  // On a tie the port granted last time yields.
  always_comb begin
    pick = S0_ARVALID ? 1'b0 : 1'b1;
    if (S0_ARVALID && S1_ARVALID) begin
      pick = ~last_q;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      last_q <= 1'b1;
    end else if (grant) begin
      last_q <= pick;
    end
  end
`else
  assign pick = S0_ARVALID ? 1'b0 : 1'b1;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= StIdle;
      gnt_q     <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant) begin
            state_q   <= StAddr;
            gnt_q     <= pick;
            arvalid_q <= 1'b1;
          end
        end
        StAddr: begin
          if (M_AXI_ARREADY) begin
            state_q   <= StIdle;
            arvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          arvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = gnt_q ? S1_ARADDR : S0_ARADDR;
  assign M_AXI_ARLEN   = ArLenFull[7:0];
  assign S0_ARREADY    = arvalid_q & ~gnt_q & M_AXI_ARREADY;
  assign S1_ARREADY    = arvalid_q & gnt_q & M_AXI_ARREADY;

  vram_rdarb_ordfifo #(
    .Depth (OUTSTANDING)
  ) u_ordfifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (ar_hs),
    .din   (gnt_q),
    .pop   (r_pop),
    .full  (ord_full),
    .empty (ord_empty),
    .head  (ord_head)
  );

  // With nothing outstanding, stray R traffic is neither accepted nor forwarded.
  assign r_sel0       = ~ord_empty & ~ord_head;
  assign r_sel1       = ~ord_empty & ord_head;
  assign S0_RVALID    = r_sel0 & M_AXI_RVALID;
  assign S1_RVALID    = r_sel1 & M_AXI_RVALID;
  assign M_AXI_RREADY = (r_sel0 & S0_RREADY) | (r_sel1 & S1_RREADY);
  assign r_pop        = M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST;

  assign S0_RDATA = M_AXI_RDATA;
  assign S1_RDATA = M_AXI_RDATA;
  assign S0_RLAST = M_AXI_RLAST;
  assign S1_RLAST = M_AXI_RLAST;

  assign BUSY = ~ord_empty | arvalid_q;

endmodule

// File: tb/tb_vram_rdarb.sv
// Scoreboard bench for vram_rdarb: AXI slave and reader models, per-port expected-beat queues.
module tb_vram_rdarb;

  localparam int unsigned BL  = 64;
  localparam int unsigned OUT = 4;
  localparam int unsigned DW  = 64;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   s_araddr [2];
  logic [1:0]    s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [DW-1:0] s_rdata [2];
  logic [31:0]   m_araddr;
  logic [7:0]    m_arlen;
  logic          m_arvalid, m_arready;
  logic [DW-1:0] m_rdata;
  logic          m_rlast, m_rvalid, m_rready;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  bit r_hold        = 1'b0;
  bit r_gaps        = 1'b0;
  bit rready_rand   = 1'b0;
  bit ar_delay_rand = 1'b0;
  int ar_delay_fix  = 0;
  int stall_cnt     = 0;

  logic [31:0] req_q [2][$];

  // Reference model: each port receives its own bursts, in its own issue order.
  logic [31:0] aq [2][$];
  int          bcnt [2];
  int          beats_seen [2];
  int          outstanding = 0;
  int          ar_count    = 0;
  int          ar_port_log [$];
  logic [31:0] last_ar_addr;
  bit          ar_hs_s [2];
  bit          m_ar_hs, m_r_hs;

  logic [31:0] rb_q [$];
  int          rbeat   = 0;
  int          ar_wait = 0;

  vram_rdarb dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S0_ARADDR     (s_araddr[0]),
    .S0_ARVALID    (s_arvalid[0]),
    .S0_ARREADY    (s_arready[0]),
    .S0_RDATA      (s_rdata[0]),
    .S0_RVALID     (s_rvalid[0]),
    .S0_RLAST      (s_rlast[0]),
    .S0_RREADY     (s_rready[0]),
    .S1_ARADDR     (s_araddr[1]),
    .S1_ARVALID    (s_arvalid[1]),
    .S1_ARREADY    (s_arready[1]),
    .S1_RDATA      (s_rdata[1]),
    .S1_RVALID     (s_rvalid[1]),
    .S1_RLAST      (s_rlast[1]),
    .S1_RREADY     (s_rready[1]),
    .M_AXI_ARADDR  (m_araddr),
    .M_AXI_ARLEN   (m_arlen),
    .M_AXI_ARVALID (m_arvalid),
    .M_AXI_ARREADY (m_arready),
    .M_AXI_RDATA   (m_rdata),
    .M_AXI_RLAST   (m_rlast),
    .M_AXI_RVALID  (m_rvalid),
    .M_AXI_RREADY  (m_rready),
    .BUSY          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs change only just after posedge, so values at negedge are what the next
  // posedge sees.
  always @(negedge clk) begin : monitor
    int hp;
    logic [63:0] exp_d;
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        aq[p].delete();
        bcnt[p]    = 0;
        ar_hs_s[p] = 1'b0;
      end
      outstanding = 0;
      m_ar_hs     = 1'b0;
      m_r_hs      = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        ar_hs_s[p] = s_arvalid[p] && s_arready[p];
        if (ar_hs_s[p]) aq[p].push_back(s_araddr[p]);
      end
      m_ar_hs = m_arvalid && m_arready;
      if (m_ar_hs) begin
        hp = s_arready[1] ? 1 : 0;
        chk("arready_onehot", 64'($countones(s_arready)), 64'd1);
        chk("araddr_mux", 64'(m_araddr), 64'(s_araddr[hp]));
        chk("arlen", 64'(m_arlen), 64'(BL - 1));
        chk("outstanding_limit", 64'(outstanding < OUT), 64'd1);
        outstanding++;
        ar_count++;
        ar_port_log.push_back(hp);
        last_ar_addr = m_araddr;
        rb_q.push_back(m_araddr);
      end else if (s_arready != 2'b00) begin
        chk("arready_spurious", 64'(s_arready), 64'd0);
      end
      if (s_rvalid == 2'b11) chk("rvalid_onehot", 64'($countones(s_rvalid)), 64'd1);
      m_r_hs = m_rvalid && m_rready;
      if (m_r_hs) chk("beat_delivered", 64'(|(s_rvalid & s_rready)), 64'd1);
      for (int p = 0; p < 2; p++) begin
        if (s_rvalid[p] && s_rready[p]) begin
          if (aq[p].size() == 0) begin
            chk($sformatf("r_unexpected_s%0d", p), 64'(s_rvalid[p]), 64'd0);
          end else begin
            exp_d = {aq[p][0], 32'(bcnt[p])};
            chk($sformatf("rdata_s%0d", p), s_rdata[p], exp_d);
            chk($sformatf("rlast_s%0d", p), 64'(s_rlast[p]), 64'(bcnt[p] == BL - 1));
            bcnt[p]++;
            beats_seen[p]++;
            if (bcnt[p] == BL) begin
              void'(aq[p].pop_front());
              bcnt[p] = 0;
              outstanding--;
            end
          end
        end
      end
    end
  end

  // Readers, AXI slave AR/R side and per-port RREADY, all driven just after posedge.
  initial begin : bfm
    s_araddr[0] = '0;
    s_araddr[1] = '0;
    s_arvalid   = '0;
    s_rready    = '0;
    m_arready   = 1'b0;
    m_rvalid    = 1'b0;
    m_rlast     = 1'b0;
    m_rdata     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        s_arvalid = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        rb_q.delete();
        rbeat   = 0;
        ar_wait = ar_delay_fix;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (ar_hs_s[p]) s_arvalid[p] = 1'b0;
          if (!s_arvalid[p] && req_q[p].size() > 0) begin
            s_araddr[p]  = req_q[p].pop_front();
            s_arvalid[p] = 1'b1;
          end
        end
        if (m_ar_hs) begin
          m_arready = 1'b0;
          ar_wait   = ar_delay_rand ? int'($urandom_range(0, 3)) : ar_delay_fix;
        end else if (m_arvalid && !m_arready) begin
          if (ar_wait == 0) m_arready = 1'b1;
          else ar_wait--;
        end
        if (m_r_hs) begin
          m_rvalid = 1'b0;
          rbeat++;
          if (rbeat == BL) begin
            rbeat = 0;
            void'(rb_q.pop_front());
          end
        end
        if (!m_rvalid && !r_hold && rb_q.size() > 0 && (!r_gaps || $urandom_range(0, 3) != 0)) begin
          m_rvalid = 1'b1;
          m_rdata  = {rb_q[0], 32'(rbeat)};
          m_rlast  = (rbeat == BL - 1);
        end else if (!m_rvalid) begin
          m_rlast = 1'b0;
          m_rdata = {$urandom, $urandom};
        end
        for (int p = 0; p < 2; p++) begin
          if (p == 0 && stall_cnt > 0) begin
            s_rready[0] = 1'b0;
            stall_cnt--;
          end else begin
            s_rready[p] = rready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((req_q[0].size() + req_q[1].size() != 0 || s_arvalid != 2'b00 ||
            aq[0].size() + aq[1].size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: traffic not drained after %0d cycles", budget);
    end else begin
      repeat (2) @(negedge clk);
      chk("busy_idle", 64'(busy), 64'd0);
    end
  endtask

  task automatic wait_beats(input int port, input int target, input int budget);
    int n = 0;
    while (beats_seen[port] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_beats: port %0d reached %0d of %0d beats", port, beats_seen[port], target);
    end
  endtask

  initial begin : main
    int base_ar, base_log, base_b, n, exp_port;
    beats_seen[0] = 0;
    beats_seen[1] = 0;
    repeat (3) @(negedge clk);
    chk("reset_arvalid", 64'(m_arvalid), 64'd0);
    chk("reset_rready", 64'(m_rready), 64'd0);
    chk("reset_arready", 64'(s_arready), 64'd0);
    chk("reset_rvalid", 64'(s_rvalid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_arlen", 64'(m_arlen), 64'(BL - 1));
    #2 rst_n = 1'b1;

    // Both ports request together right after reset: port 0 must win the first tie.
    ar_delay_fix = 1;
    base_log = ar_port_log.size();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_q[0].push_back(32'h1000_0000 + 32'(i) * 32'h1000);
      req_q[1].push_back(32'h1800_0000 + 32'(i) * 32'h1000);
    end
    wait_idle(5000);
    chk("grant_count", 64'(ar_port_log.size() - base_log), 64'd8);
    for (int i = 0; i < 8 && base_log + i < ar_port_log.size(); i++) begin
`ifdef VRAM_RDARB_RR_EN
      exp_port = i % 2;
`else
      exp_port = i / 4;
`endif
      chk($sformatf("grant_order_%0d", i), 64'(ar_port_log[base_log + i]), 64'(exp_port));
    end

    // Single port-0 burst with ARREADY delayed.
    ar_delay_fix = 2;
    base_ar = ar_count;
    base_b  = beats_seen[0];
    req_q[0].push_back(32'h2000_0000);
    n = 0;
    while (!s_arvalid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_latency_same_cycle", 64'(m_arvalid), 64'd0);
    @(negedge clk);
    chk("ar_latency_next_cycle", 64'(m_arvalid), 64'd1);
    wait_idle(2000);
    chk("single_ar_count", 64'(ar_count - base_ar), 64'd1);
    chk("single_ar_addr", 64'(last_ar_addr), 64'h2000_0000);
    chk("single_beats", 64'(beats_seen[0] - base_b), 64'(BL));

    // R withheld: only OUTSTANDING bursts may be accepted.
    ar_delay_fix = 0;
    r_hold  = 1'b1;
    base_ar = ar_count;
    for (int i = 0; i < 5; i++) req_q[1].push_back(32'h3000_0000 + 32'(i) * 32'h1000);
    repeat (40) @(negedge clk);
    chk("stalled_ar_count", 64'(ar_count - base_ar), 64'(OUT));
    chk("stalled_busy", 64'(busy), 64'd1);
    r_hold = 1'b0;
    wait_idle(5000);
    chk("released_ar_count", 64'(ar_count - base_ar), 64'd5);

    // Port 0 back-pressures mid-burst while port 1 has a burst queued behind it.
    base_b = beats_seen[0];
    req_q[0].push_back(32'h4000_0000);
    req_q[1].push_back(32'h4800_0000);
    wait_beats(0, base_b + 10, 500);
    stall_cnt = 10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_m_rready", 64'(m_rready), 64'd0);
      chk("stall_s1_rvalid", 64'(s_rvalid[1]), 64'd0);
    end
    wait_idle(3000);

    // Random traffic.
    r_gaps        = 1'b1;
    rready_rand   = 1'b1;
    ar_delay_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      req_q[$urandom_range(0, 1)].push_back($urandom);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_idle(30000);

    // Asynchronous reset during beat 20 of a burst.
    r_gaps        = 1'b0;
    rready_rand   = 1'b0;
    ar_delay_rand = 1'b0;
    base_b = beats_seen[0];
    req_q[0].push_back(32'h5000_0000);
    req_q[1].push_back(32'h5800_0000);
    wait_beats(0, base_b + 19, 500);
    #2 rst_n = 1'b0;
    #1;
    req_q[0].delete();
    req_q[1].delete();
    stall_cnt = 0;
    chk("async_rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("async_rst_rready", 64'(m_rready), 64'd0);
    chk("async_rst_arready", 64'(s_arready), 64'd0);
    chk("async_rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    base_ar = ar_count;
    base_b  = beats_seen[1];
    req_q[1].push_back(32'h6000_0000);
    wait_idle(2000);
    chk("post_rst_ar_count", 64'(ar_count - base_ar), 64'd1);
    chk("post_rst_port", 64'(ar_port_log[ar_port_log.size() - 1]), 64'd1);
    chk("post_rst_beats", 64'(beats_seen[1] - base_b), 64'(BL));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached with %0d of %0d checks failing", n_fail, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vram_rdarb.md
VRAM_RDARB -- requirements
Module: vram_rdarb

Interface
REQ-001 SHALL have parameter BURSTLEN, default 9'd64: beats per read burst; ARLEN = BURSTLEN-1 on every request.
REQ-002 SHALL have parameter OUTSTANDING, default 4: maximum accepted bursts not yet completed (power of 2, 2..16).
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 64: read data width.
REQ-004 ACLK  in  1  single clock for all logic; ARESETN  in  1  asynchronous active-low reset.
REQ-005 S0_ARADDR  in  32  port 0 (display VRAM fetch) burst address; S0_ARVALID in 1; S0_ARREADY out 1.
REQ-006 S0_RDATA out C_M_AXI_DATA_WIDTH; S0_RVALID out 1; S0_RLAST out 1; S0_RREADY in 1: port 0 read data.
REQ-007 S1_* : identical set for port 1 (secondary reader, e.g. overlay/capture readback).
REQ-008 M_AXI_ARADDR out 32, M_AXI_ARLEN out 8, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1: shared AR channel.
REQ-009 M_AXI_RDATA in C_M_AXI_DATA_WIDTH, M_AXI_RLAST in 1, M_AXI_RVALID in 1, M_AXI_RREADY out 1: shared R channel.
REQ-010 BUSY out 1: high while the order FIFO is non-empty or an AR is pending.

Function
REQ-011 SHALL run an AR FSM with states IDLE and ADDR; reset state IDLE.
REQ-012 IDLE: when order FIFO not full and any SX_ARVALID, latch grant GNT and go to ADDR next cycle; else stay.
REQ-013 Default arbitration SHALL be fixed priority, port 0 over port 1.
REQ-014 ADDR: M_AXI_ARVALID=1, M_AXI_ARADDR=S{GNT}_ARADDR (muxed, not re-registered); GNT SHALL not change until handshake.
REQ-015 S{GNT}_ARREADY = M_AXI_ARREADY in ADDR; other port ARREADY=0; all ARREADY=0 in IDLE.
REQ-016 On M_AXI_ARVALID&M_AXI_ARREADY: push GNT into order FIFO, return to IDLE (one idle cycle between grants).
REQ-017 R routing: head entry H of order FIFO selects port; S{H}_RVALID=M_AXI_RVALID, M_AXI_RREADY=S{H}_RREADY; other port RVALID=0.
REQ-018 FIFO empty: M_AXI_RREADY=0, both SX_RVALID=0; stray M_AXI_RVALID SHALL be ignored (no pop).
REQ-019 RDATA and RLAST SHALL be broadcast combinationally to both ports; only RVALID qualifies.
REQ-020 Pop on M_AXI_RVALID&M_AXI_RREADY&M_AXI_RLAST; beats without RLAST do not pop.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo OUTSTANDING.
REQ-022 FIFO full (count==OUTSTANDING): FSM SHALL stay in IDLE; a grant already in ADDR still completes (full checked at grant, so no overflow).
REQ-023 Zero-cycle latency from M_AXI_R* to SX_R*; one cycle from SX_ARVALID to M_AXI_ARVALID.

Reset
REQ-024 ARESETN low SHALL asynchronously force: FSM IDLE, GNT=0, FIFO pointers/count 0, M_AXI_ARVALID=0, M_AXI_RREADY=0, all SX_ARREADY/SX_RVALID=0, BUSY=0.
REQ-025 Reset mid-burst SHALL discard all outstanding entries; no recovery of in-flight beats.
REQ-026 M_AXI_ARLEN is constant BURSTLEN-1 regardless of reset.

Configuration
REQ-027 Macro VRAM_RDARB_RR_EN defined: round-robin, last-granted port loses ties; undefined: fixed priority per REQ-013.
REQ-028 With VRAM_RDARB_RR_EN, last-granted register resets to port 1 (port 0 wins first tie).

Structure
REQ-029 Shared package vram_rdarb_pkg SHALL hold port-ID type (1 bit), FSM state enum, and default BURSTLEN/OUTSTANDING constants.
REQ-030 Order FIFO SHALL be sub-module vram_rdarb_ordfifo (depth OUTSTANDING, width 1, push/pop/full/empty/head).

Verification
REQ-031 S0 only, ARADDR 0x2000_0000, slave ARREADY after 2 cycles, 64 beats -> one AR, ARLEN=0x3F, S0 sees 64 RVALID, RLAST on beat 64, BUSY low after.
REQ-032 S0 and S1 ARVALID same cycle, fixed priority -> S0 granted first, S1 next grant; R beats routed S0 then S1 in AR order.
REQ-033 Same with VRAM_RDARB_RR_EN, 4 back-to-back requests each -> grants alternate S0,S1,S0,S1...
REQ-034 Slave withholds R, 5 requests from S1 -> exactly 4 ARs issued, 5th after first RLAST pop.
REQ-035 S0_RREADY held low 10 cycles mid-burst -> M_AXI_RREADY low those cycles, S1 RVALID stays 0, no beat lost.
REQ-036 ARESETN low during beat 20 of a burst -> outputs zero immediately, BUSY=0, next S1 request granted normally.
